ultrasonic_ranger_ctrl: RTL and testbench
=========================================

Name: ultrasonic_ranger_ctrl

Overview:
Sequencer for an HC-SR04-style ultrasonic range sensor. It generates the trigger pulse, waits for the echo, and measures the echo high time in clock cycles. It also enforces a timeout and a minimum repeat period, and reports each result with a one-cycle valid strobe. It sits between the GPIO sensor pins and display/LED logic, replacing free-running edge counting with a controlled measurement cycle.

Parameters:
TRIG_CYCLES, 500, trigger high time in clocks (10 us at 50 MHz)
TIMEOUT_CYCLES, 1500000, max clocks from trigger fall to echo fall (30 ms)
PERIOD_CYCLES, 3000000, min clocks between successive trigger rises (60 ms); must be > TRIG_CYCLES + TIMEOUT_CYCLES
CNT_W, 32, width of counters and result

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
auto_mode  in  1  1 = re-trigger every PERIOD_CYCLES; 0 = single-shot via start
start  in  1  single-shot request pulse; honoured only in IDLE
echo  in  1  raw sensor echo (asynchronous)
trigger  out  1  sensor trigger, registered
busy  out  1  high in every state except IDLE
result_valid  out  1  one-cycle strobe, result_width updated
result_width  out  CNT_W  echo high time in clocks
timeout  out  1  one-cycle strobe, measurement aborted

Behaviour:
- Reset values: trigger=0, busy=0, result_valid=0, result_width=0, timeout=0, state=IDLE, all counters=0, echo sync flops=0.
- echo passes through a 2-flop synchronizer, then a third flop for edge detection. rise = s & ~s_d; fall = ~s & s_d. Edge detection adds 3 cycles of latency from the pin.
- States:
  - IDLE: go to TRIG when start=1 or auto_mode=1.
  - TRIG: trigger=1 for exactly TRIG_CYCLES clocks, then go to WAIT_RISE. The period counter starts at 0 on the first TRIG cycle.
  - WAIT_RISE: timeout counter counts from 0 at entry. Rise goes to MEASURE with the width counter cleared to 1. An echo already high at entry is ignored until it goes low and rises again.
  - MEASURE: width counter increments each cycle sync echo is high; it saturates at all-ones. On fall: result_width <= width counter, result_valid=1 for one cycle, go to HOLDOFF.
  - HOLDOFF: wait until the period counter reaches PERIOD_CYCLES-1. Then go to TRIG if auto_mode=1, otherwise IDLE.
- Timeout counter keeps running through WAIT_RISE and MEASURE. On reaching TIMEOUT_CYCLES-1: timeout=1 for one cycle, result_width unchanged, go to HOLDOFF.
- If fall and timeout expiry occur in the same cycle, fall wins: result_valid=1, timeout=0.
- result_valid and timeout are never high together.
- start outside IDLE is ignored, not queued. auto_mode is sampled only in IDLE and at HOLDOFF exit.
- Reset asserted mid-operation: trigger drops immediately (asynchronous), all state returns to reset values, and no strobe is emitted.
- The period counter saturates and does not wrap.

Test Plan:
- Reset held, echo toggling -> trigger=0, busy=0, no strobes. Release, auto_mode=0, no start -> stays IDLE.
- auto_mode=0, start pulse, echo rises 1000 clocks after trigger fall and stays high 58000 clocks -> trigger high exactly 500 clocks; result_valid once with result_width=58000; busy falls 3000000 clocks after trigger rise.
- Echo never rises -> timeout strobe exactly TIMEOUT_CYCLES clocks after trigger fall; result_width keeps its previous value; no result_valid.
- auto_mode=1, echo width 20000 each cycle -> trigger rises every 3000000 clocks, and each cycle gives result_valid with result_width=20000. Start pulses during busy have no effect.
- Echo high when WAIT_RISE is entered, falls, then rises for 5000 clocks -> result_width=5000. Separately, align echo fall with timeout expiry -> result_valid=1, timeout=0.
- Assert reset mid-MEASURE -> trigger=0 and busy=0 asynchronously, no strobe; a restart then measures correctly.

Source files
------------

// File: rtl/ultrasonic_ranger_ctrl.sv
// Measurement sequencer for an HC-SR04-style ultrasonic ranger: trigger pulse,
// echo wait, echo width count, timeout and minimum repeat period.
module ultrasonic_ranger_ctrl #(
    parameter int TRIG_CYCLES    = 500,
    parameter int TIMEOUT_CYCLES = 1500000,
    parameter int PERIOD_CYCLES  = 3000000,
    parameter int CNT_W          = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             auto_mode,
    input  logic             start,
    input  logic             echo,
    output logic             trigger,
    output logic             busy,
    output logic             result_valid,
    output logic [CNT_W-1:0] result_width,
    output logic             timeout
);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        HOLDOFF
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);

    state_t state, state_next;

    logic echo_meta, echo_sync, echo_dly;
    logic echo_rise, echo_fall;
    logic timeout_hit;
    logic valid_next, timeout_next;

    logic [CNT_W-1:0] trig_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] timeout_cnt;
    logic [CNT_W-1:0] width_cnt;

    // Two flops for metastability, a third to find edges of the clean signal.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            echo_meta <= 1'b0;
            echo_sync <= 1'b0;
            echo_dly  <= 1'b0;
        end else begin
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_dly  <= echo_sync;
        end
    end

    assign echo_rise   = echo_sync & ~echo_dly;
    assign echo_fall   = ~echo_sync & echo_dly;
    assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);
    assign busy        = (state != IDLE);

    always_comb begin
        state_next   = state;
        valid_next   = 1'b0;
        timeout_next = 1'b0;
        case (state)
            IDLE: begin
                if (start || auto_mode) state_next = TRIG;
            end
            TRIG: begin
                if (trig_cnt == TRIG_LAST) state_next = WAIT_RISE;
            end
            WAIT_RISE: begin
                // Expiry beats a simultaneous rise so a measurement never starts past the deadline.
                if (timeout_hit) begin
                    timeout_next = 1'b1;
                    state_next   = HOLDOFF;
                end else if (echo_rise) begin
                    state_next = MEASURE;
                end
            end
            MEASURE: begin
                if (echo_fall) begin
                    valid_next = 1'b1;
                    state_next = HOLDOFF;
                end else if (timeout_hit) begin
                    timeout_next = 1'b1;
                    state_next   = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (period_cnt >= PERIOD_LAST) state_next = auto_mode ? TRIG : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            trigger      <= 1'b0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            result_width <= '0;
        end else begin
            state        <= state_next;
            trigger      <= (state_next == TRIG);
            result_valid <= valid_next;
            timeout      <= timeout_next;
            if (valid_next) result_width <= width_cnt;
        end
    end

    // Period counter restarts on each trigger rise and saturates instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_cnt    <= '0;
            period_cnt  <= '0;
            timeout_cnt <= '0;
            width_cnt   <= '0;
        end else begin
            if (state == TRIG) trig_cnt <= trig_cnt + CNT_ONE;
            else               trig_cnt <= '0;

            if (state != TRIG && state_next == TRIG) period_cnt <= '0;
            else if (period_cnt != CNT_MAX)          period_cnt <= period_cnt + CNT_ONE;

            if (state == WAIT_RISE || state == MEASURE) timeout_cnt <= timeout_cnt + CNT_ONE;
            else                                        timeout_cnt <= '0;

            if (state == WAIT_RISE && echo_rise)
                width_cnt <= CNT_ONE;
            else if (state == MEASURE && echo_sync && width_cnt != CNT_MAX)
                width_cnt <= width_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// Directed bench for ultrasonic_ranger_ctrl using scaled-down timing parameters
// so that full measurement cycles fit in a short run.
module tb_ultrasonic_ranger_ctrl;

    localparam int TRIG = 5;
    localparam int TMO  = 200;
    localparam int PER  = 400;
    localparam int W    = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         auto_mode;
    logic         start;
    logic         echo;
    logic         trigger;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] result_width;
    logic         timeout;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rv_count = 0;
    int to_count = 0;
    int both_count = 0;
    int rise_cyc, fall_cyc, strobe_cyc, idle_cyc, trig_len, prev_rise;

    ultrasonic_ranger_ctrl #(
        .TRIG_CYCLES(TRIG),
        .TIMEOUT_CYCLES(TMO),
        .PERIOD_CYCLES(PER),
        .CNT_W(W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .auto_mode(auto_mode),
        .start(start),
        .echo(echo),
        .trigger(trigger),
        .busy(busy),
        .result_valid(result_valid),
        .result_width(result_width),
        .timeout(timeout)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (result_valid)            rv_count   <= rv_count + 1;
        if (timeout)                 to_count   <= to_count + 1;
        if (result_valid && timeout) both_count <= both_count + 1;
    end

    task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Echo goes high after delay_cycles and stays high for high_cycles.
    task applyStimulus(input int delay_cycles, input int high_cycles);
        repeat (delay_cycles) @(negedge clock);
        echo = 1'b1;
        repeat (high_cycles) @(negedge clock);
        echo = 1'b0;
    endtask

    task waitTriggerRise();
        int n;
        n = 0;
        while (trigger !== 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        rise_cyc = cyc;
        checkOutput("trigger_rise_seen", trigger, 1);
    endtask

    task waitTriggerFall();
        trig_len = 0;
        while (trigger === 1'b1 && trig_len < 1000) begin
            trig_len++;
            @(negedge clock);
        end
        fall_cyc = cyc;
        checkOutput("trigger_high_len", trig_len, TRIG);
    endtask

    task waitStrobe();
        int n;
        n = 0;
        while (!(result_valid === 1'b1 || timeout === 1'b1) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        strobe_cyc = cyc;
    endtask

    task waitIdle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        idle_cyc = cyc;
        checkOutput("busy_drop", busy, 0);
    endtask

    initial begin
        reset     = 1'b1;
        auto_mode = 1'b0;
        start     = 1'b0;
        echo      = 1'b0;

        // Reset held while echo toggles
        repeat (10) begin
            @(negedge clock);
            echo = ~echo;
        end
        checkOutput("reset_trigger", trigger, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_valid", result_valid, 0);
        checkOutput("reset_timeout", timeout, 0);
        checkOutput("reset_width", result_width, 0);
        @(negedge clock);
        echo  = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_trigger", trigger, 0);
        checkOutput("idle_no_strobe", rv_count + to_count, 0);

        // Single-shot measurement, start pulse in HOLDOFF must be ignored
        pulseStart();
        waitTriggerRise();
        waitTriggerFall();
        applyStimulus(20, 100);
        waitStrobe();
        checkOutput("t2_valid", result_valid, 1);
        checkOutput("t2_timeout", timeout, 0);
        checkOutput("t2_width", result_width, 100);
        @(negedge clock);
        checkOutput("t2_valid_one_cycle", result_valid, 0);
        pulseStart();
        waitIdle();
        checkOutput("t2_busy_period", idle_cyc - rise_cyc, PER);
        repeat (20) @(negedge clock);
        checkOutput("t2_start_not_queued", busy, 0);
        checkOutput("t2_rv_count", rv_count, 1);

        // Echo never rises
        pulseStart();
        waitTriggerRise();
        waitTriggerFall();
        waitStrobe();
        checkOutput("t3_timeout", timeout, 1);
        checkOutput("t3_valid", result_valid, 0);
        checkOutput("t3_timeout_delay", strobe_cyc - fall_cyc, TMO);
        checkOutput("t3_width_kept", result_width, 100);
        @(negedge clock);
        checkOutput("t3_timeout_one_cycle", timeout, 0);
        waitIdle();
        checkOutput("t3_rv_count", rv_count, 1);
        checkOutput("t3_to_count", to_count, 1);

        // Auto mode, three periods, start pulses during busy
        auto_mode = 1'b1;
        prev_rise = 0;
        for (int n = 0; n < 3; n++) begin
            waitTriggerRise();
            if (n > 0) checkOutput("t4_rise_spacing", rise_cyc - prev_rise, PER);
            prev_rise = rise_cyc;
            waitTriggerFall();
            applyStimulus(10, 30);
            waitStrobe();
            checkOutput("t4_valid", result_valid, 1);
            checkOutput("t4_width", result_width, 30);
            pulseStart();
            if (n == 2) auto_mode = 1'b0;
        end
        waitIdle();
        checkOutput("t4_last_period", idle_cyc - prev_rise, PER);
        checkOutput("t4_rv_count", rv_count, 4);

        // Echo already high when WAIT_RISE is entered
        pulseStart();
        waitTriggerRise();
        echo = 1'b1;
        waitTriggerFall();
        repeat (10) @(negedge clock);
        echo = 1'b0;
        applyStimulus(10, 50);
        waitStrobe();
        checkOutput("t5a_valid", result_valid, 1);
        checkOutput("t5a_width", result_width, 50);
        waitIdle();

        // Echo fall lands in the same cycle as timeout expiry
        pulseStart();
        waitTriggerRise();
        waitTriggerFall();
        applyStimulus(10, TMO - 13);
        waitStrobe();
        checkOutput("t5b_valid", result_valid, 1);
        checkOutput("t5b_timeout", timeout, 0);
        checkOutput("t5b_strobe_delay", strobe_cyc - fall_cyc, TMO);
        checkOutput("t5b_width", result_width, TMO - 13);
        waitIdle();
        checkOutput("t5b_to_count", to_count, 1);

        // Asynchronous reset during TRIG
        pulseStart();
        waitTriggerRise();
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_trig_async_trigger", trigger, 0);
        checkOutput("t6_trig_async_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Asynchronous reset during MEASURE, then a clean restart
        pulseStart();
        waitTriggerRise();
        waitTriggerFall();
        repeat (10) @(negedge clock);
        echo = 1'b1;
        repeat (30) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_meas_async_busy", busy, 0);
        checkOutput("t6_meas_async_trigger", trigger, 0);
        checkOutput("t6_meas_valid", result_valid, 0);
        @(negedge clock);
        echo = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("t6_width_reset", result_width, 0);
        checkOutput("t6_rv_count", rv_count, 6);
        checkOutput("t6_to_count", to_count, 1);
        pulseStart();
        waitTriggerRise();
        waitTriggerFall();
        applyStimulus(15, 40);
        waitStrobe();
        checkOutput("t6_restart_valid", result_valid, 1);
        checkOutput("t6_restart_width", result_width, 40);
        waitIdle();
        checkOutput("final_rv_count", rv_count, 7);
        checkOutput("final_to_count", to_count, 1);
        checkOutput("final_never_both", both_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
